// File: rtl/pixel_stream_rx.sv
// Raster pixel stream receiver: rebuilds X/Y from SOF/EOL flags and drives a registered framebuffer write port.
// Optional per-frame XOR checksum on frame_sum when PIXEL_RX_CHECKSUM_EN is defined.
module pixel_stream_rx #(
  parameter int H_ACTIVE = 1024,
  parameter int V_ACTIVE = 768,
  parameter int XW       = 10,
  parameter int YW       = 10,
  parameter int DATA_W   = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_sof,
  input  logic              s_eol,
  input  logic              fb_busy,
  output logic              fb_we,
  output logic [XW-1:0]     fb_x,
  output logic [YW-1:0]     fb_y,
  output logic [DATA_W-1:0] fb_data,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic              err_sof,
  output logic              err_eol,
  output logic [DATA_W-1:0] frame_sum
);

  typedef enum logic [0:0] {
    WAIT_SOF = 1'b0,
    ACTIVE   = 1'b1
  } state_t;

  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  state_t          state;
  state_t          state_nxt;
  logic [XW-1:0]   x;
  logic [XW-1:0]   x_nxt;
  logic [YW-1:0]   y;
  logic [YW-1:0]   y_nxt;
  logic            accept;
  logic            wr;
  logic [XW-1:0]   wr_x;
  logic [YW-1:0]   wr_y;
  logic            done;
  logic            set_err_sof;
  logic            set_err_eol;
  logic            frame_start;

  // Ready depends only on reset and framebuffer backpressure, never on s_valid.
  assign s_ready = !rst && !fb_busy;
  assign accept  = s_valid && s_ready;

  // Raster position and frame state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_SOF;
      x     <= {XW{1'b0}};
      y     <= {YW{1'b0}};
    end else begin
      state <= state_nxt;
      x     <= x_nxt;
      y     <= y_nxt;
    end
  end

  // Next-state, write-request and error decode for one accepted beat.
  always_comb begin
    state_nxt   = state;
    x_nxt       = x;
    y_nxt       = y;
    wr          = 1'b0;
    wr_x        = x;
    wr_y        = y;
    done        = 1'b0;
    set_err_sof = 1'b0;
    set_err_eol = 1'b0;
    frame_start = 1'b0;
    case (state)
      WAIT_SOF: begin
        if (accept && s_sof) begin
          wr          = 1'b1;
          wr_x        = {XW{1'b0}};
          wr_y        = {YW{1'b0}};
          x_nxt       = XW'(1);
          y_nxt       = {YW{1'b0}};
          state_nxt   = ACTIVE;
          frame_start = 1'b1;
        end else begin
          state_nxt = WAIT_SOF;
        end
      end
      ACTIVE: begin
        if (accept && s_sof) begin
          // A SOF mid-frame restarts the raster at the origin with this beat.
          set_err_sof = 1'b1;
          wr          = 1'b1;
          wr_x        = {XW{1'b0}};
          wr_y        = {YW{1'b0}};
          x_nxt       = XW'(1);
          y_nxt       = {YW{1'b0}};
          frame_start = 1'b1;
        end else if (accept) begin
          wr = 1'b1;
          if ((x == X_LAST) != s_eol) begin
            set_err_eol = 1'b1;
          end else begin
            set_err_eol = 1'b0;
          end
          if ((x == X_LAST) || s_eol) begin
            x_nxt = {XW{1'b0}};
            if (y == Y_LAST) begin
              y_nxt     = {YW{1'b0}};
              done      = 1'b1;
              state_nxt = WAIT_SOF;
            end else begin
              y_nxt = y + YW'(1);
            end
          end else begin
            x_nxt = x + XW'(1);
          end
        end else begin
          state_nxt = ACTIVE;
        end
      end
      default: begin
        state_nxt = WAIT_SOF;
        x_nxt     = {XW{1'b0}};
        y_nxt     = {YW{1'b0}};
      end
    endcase
  end

  // Registered framebuffer port; coordinates and data hold between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      fb_we   <= 1'b0;
      fb_x    <= {XW{1'b0}};
      fb_y    <= {YW{1'b0}};
      fb_data <= {DATA_W{1'b0}};
    end else begin
      fb_we <= wr;
      if (wr) begin
        fb_x    <= wr_x;
        fb_y    <= wr_y;
        fb_data <= s_data;
      end
    end
  end

  // Frame completion pulse, frame counter and sticky geometry errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done  <= 1'b0;
      frame_count <= 16'h0000;
      err_sof     <= 1'b0;
      err_eol     <= 1'b0;
    end else begin
      frame_done <= done;
      if (done) begin
        frame_count <= frame_count + 16'h0001;
      end
      if (set_err_sof) begin
        err_sof <= 1'b1;
      end
      if (set_err_eol) begin
        err_eol <= 1'b1;
      end
    end
  end

`ifdef PIXEL_RX_CHECKSUM_EN
  logic [DATA_W-1:0] sum_acc;

  // Running XOR of the frame's written data; published together with frame_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_acc   <= {DATA_W{1'b0}};
      frame_sum <= {DATA_W{1'b0}};
    end else begin
      if (frame_start) begin
        sum_acc <= s_data;
      end else if (wr) begin
        sum_acc <= sum_acc ^ s_data;
      end
      if (done) begin
        frame_sum <= sum_acc ^ s_data;
      end
    end
  end
`else
  assign frame_sum = {DATA_W{1'b0}};
`endif

endmodule

// File: tb/tb_pixel_stream_rx.sv
// Directed bench for pixel_stream_rx with a 4x3 raster; frame_sum expectation follows PIXEL_RX_CHECKSUM_EN.
module tb_pixel_stream_rx;

  localparam int H = 4;
  localparam int V = 3;
  localparam int XW = 2;
  localparam int YW = 2;
  localparam int DW = 24;
`ifdef PIXEL_RX_CHECKSUM_EN
  localparam logic [31:0] SUM_EXP = 32'h0000000C;
`else
  localparam logic [31:0] SUM_EXP = 32'h00000000;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_sof;
  logic          s_eol;
  logic          fb_busy;
  logic          fb_we;
  logic [XW-1:0] fb_x;
  logic [YW-1:0] fb_y;
  logic [DW-1:0] fb_data;
  logic          frame_done;
  logic [15:0]   frame_count;
  logic          err_sof;
  logic          err_eol;
  logic [DW-1:0] frame_sum;

  int compared = 0;
  int mismatched = 0;

  pixel_stream_rx #(.H_ACTIVE(H), .V_ACTIVE(V), .XW(XW), .YW(YW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_sof(s_sof), .s_eol(s_eol), .fb_busy(fb_busy), .fb_we(fb_we), .fb_x(fb_x),
    .fb_y(fb_y), .fb_data(fb_data), .frame_done(frame_done), .frame_count(frame_count),
    .err_sof(err_sof), .err_eol(err_eol), .frame_sum(frame_sum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat, let it be accepted, then check the write that follows one cycle later.
  task automatic beat(input logic [DW-1:0] d, input bit sof, input bit eol, input bit exp_we,
                      input int ex, input int ey, input bit exp_done);
    s_valid = 1'b1;
    s_data  = d;
    s_sof   = sof;
    s_eol   = eol;
    step();
    chk("fb_we", 32'(fb_we), 32'(exp_we));
    if (exp_we) begin
      chk("fb_x", 32'(fb_x), 32'(ex));
      chk("fb_y", 32'(fb_y), 32'(ey));
      chk("fb_data", 32'(fb_data), 32'(d));
    end
    chk("frame_done", 32'(frame_done), 32'(exp_done));
  endtask

  task automatic idle();
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_eol   = 1'b0;
    step();
    chk("idle_we", 32'(fb_we), 32'd0);
    chk("idle_done", 32'(frame_done), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("ready_in_rst", 32'(s_ready), 32'd0);
    step();
    step();
    chk("rst_we", 32'(fb_we), 32'd0);
    chk("rst_x", 32'(fb_x), 32'd0);
    chk("rst_y", 32'(fb_y), 32'd0);
    chk("rst_data", 32'(fb_data), 32'd0);
    chk("rst_count", 32'(frame_count), 32'd0);
    chk("rst_err_sof", 32'(err_sof), 32'd0);
    chk("rst_err_eol", 32'(err_eol), 32'd0);
    chk("rst_sum", 32'(frame_sum), 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(s_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_sof = 1'b0; s_eol = 1'b0; fb_busy = 1'b0;
    step();
    do_reset();

    // Pre-SOF garbage is discarded
    for (int i = 0; i < 3; i++) beat(24'hEE0 + 24'(i), 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);

    // Clean frame, data 1..12
    for (int i = 0; i < 12; i++)
      beat(24'(i + 1), i == 0, (i % H) == H - 1, 1'b1, i % H, i / H, i == 11);
    idle();
    chk("count_f1", 32'(frame_count), 32'd1);
    chk("hold_x", 32'(fb_x), 32'd3);
    chk("hold_y", 32'(fb_y), 32'd2);
    chk("sum_f1", 32'(frame_sum), SUM_EXP);
    chk("err_sof_f1", 32'(err_sof), 32'd0);
    chk("err_eol_f1", 32'(err_eol), 32'd0);

    // Backpressure mid-line
    beat(24'h100, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0);
    beat(24'h101, 1'b0, 1'b0, 1'b1, 1, 0, 1'b0);
    fb_busy = 1'b1;
    s_data = 24'h102; s_sof = 1'b0; s_eol = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("busy_ready", 32'(s_ready), 32'd0);
      step();
      chk("busy_we", 32'(fb_we), 32'd0);
      chk("busy_x_hold", 32'(fb_x), 32'd1);
    end
    fb_busy = 1'b0;
    for (int i = 2; i < 12; i++)
      beat(24'h100 + 24'(i), 1'b0, (i % H) == H - 1, 1'b1, i % H, i / H, i == 11);
    idle();
    chk("count_f2", 32'(frame_count), 32'd2);
    chk("err_eol_f2", 32'(err_eol), 32'd0);

    // Early EOL on line 0, missing EOL on line 1
    beat(24'h200, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0);
    beat(24'h201, 1'b0, 1'b1, 1'b1, 1, 0, 1'b0);
    chk("err_eol_early", 32'(err_eol), 32'd1);
    beat(24'h202, 1'b0, 1'b0, 1'b1, 0, 1, 1'b0);
    beat(24'h203, 1'b0, 1'b0, 1'b1, 1, 1, 1'b0);
    beat(24'h204, 1'b0, 1'b0, 1'b1, 2, 1, 1'b0);
    beat(24'h205, 1'b0, 1'b0, 1'b1, 3, 1, 1'b0);
    beat(24'h206, 1'b0, 1'b0, 1'b1, 0, 2, 1'b0);
    beat(24'h207, 1'b0, 1'b0, 1'b1, 1, 2, 1'b0);
    beat(24'h208, 1'b0, 1'b0, 1'b1, 2, 2, 1'b0);
    beat(24'h209, 1'b0, 1'b1, 1'b1, 3, 2, 1'b1);
    idle();
    chk("count_f3", 32'(frame_count), 32'd3);
    chk("err_eol_sticky", 32'(err_eol), 32'd1);
    chk("err_sof_f3", 32'(err_sof), 32'd0);

    // Mid-frame SOF at (2,1), restarted frame then completes
    do_reset();
    for (int i = 0; i < 6; i++)
      beat(24'h50 + 24'(i), i == 0, (i % H) == H - 1, 1'b1, i % H, i / H, 1'b0);
    beat(24'd1, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0);
    chk("err_sof_set", 32'(err_sof), 32'd1);
    for (int i = 1; i < 12; i++)
      beat(24'(i + 1), 1'b0, (i % H) == H - 1, 1'b1, i % H, i / H, i == 11);
    idle();
    chk("count_f4", 32'(frame_count), 32'd1);
    chk("sum_f4", 32'(frame_sum), SUM_EXP);
    chk("err_sof_sticky", 32'(err_sof), 32'd1);

    // Reset at (1,1) drops the pending write
    for (int i = 0; i < 5; i++)
      beat(24'h300 + 24'(i), i == 0, (i % H) == H - 1, 1'b1, i % H, i / H, 1'b0);
    s_data = 24'h305; s_sof = 1'b0; s_eol = 1'b0; s_valid = 1'b1;
    do_reset();
    beat(24'h400, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    beat(24'h401, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0);
    beat(24'h402, 1'b0, 1'b0, 1'b1, 1, 0, 1'b0);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pixel_stream_rx.md
Name: pixel_stream_rx

Overview:
Receiving end of the raster pixel stream. Consumes a valid/ready pixel stream marked with start-of-frame (SOF) and end-of-line (EOL) flags, and rebuilds the X/Y raster position for each pixel. Drives a registered framebuffer write port and flags geometry errors. Sits between the pixel source and the display framebuffer.

Parameters:
H_ACTIVE, 1024, pixels per line (X range 0..H_ACTIVE-1)
V_ACTIVE, 768, lines per frame (Y range 0..V_ACTIVE-1)
XW, 10, X coordinate width; must satisfy 2^XW >= H_ACTIVE
YW, 10, Y coordinate width; must satisfy 2^YW >= V_ACTIVE
DATA_W, 24, pixel data width (RGB888)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
s_valid  in  1  input pixel valid
s_ready  out  1  input ready; a beat transfers when s_valid && s_ready
s_data  in  DATA_W  pixel data
s_sof  in  1  beat is first pixel of frame
s_eol  in  1  beat is last pixel of line
fb_busy  in  1  framebuffer backpressure
fb_we  out  1  framebuffer write strobe
fb_x  out  XW  write X coordinate
fb_y  out  YW  write Y coordinate
fb_data  out  DATA_W  write data
frame_done  out  1  one-cycle pulse, frame complete
frame_count  out  16  completed frames, wraps 0xFFFF->0
err_sof  out  1  sticky: SOF arrived mid-frame
err_eol  out  1  sticky: EOL early or missing
frame_sum  out  DATA_W  frame checksum (see Optional Feature)

Behaviour:
- Reset values: s_ready=0 in the reset cycle; fb_we=0, fb_x=0, fb_y=0, fb_data=0, frame_done=0, frame_count=0, err_sof=0, err_eol=0, frame_sum=0; state=WAIT_SOF, internal x=0, y=0.
- s_ready = !rst && !fb_busy. It is purely combinational from fb_busy and does not depend on s_valid.
- State WAIT_SOF:
  - Accepted beats with s_sof=0 are discarded: no write, no error.
  - An accepted beat with s_sof=1 is written at (0,0), then x=1, y=0, and the state moves to ACTIVE.
- State ACTIVE, per accepted beat, in priority order:
  1. s_sof=1: set err_sof, restart the frame, write the beat at (0,0), then x=1, y=0.
  2. Otherwise write the beat at (x,y). Line end is reached when x==H_ACTIVE-1 or s_eol=1.
     - s_eol=1 with x<H_ACTIVE-1 (early EOL): set err_eol.
     - x==H_ACTIVE-1 with s_eol=0 (missing EOL): set err_eol.
     - In both cases the line is still terminated at this beat.
  3. At line end: x=0, y=y+1. If y was V_ACTIVE-1, the frame ends instead:
     - frame_done pulses,
     - frame_count increments,
     - state returns to WAIT_SOF,
     - x and y clear to 0.
  4. Otherwise x=x+1.
- Latency: a beat accepted in cycle N gives fb_we=1 in cycle N+1, with fb_x/fb_y/fb_data holding that beat's coordinates and data. fb_we is 0 in all other cycles.
- fb_x, fb_y and fb_data hold their last values when fb_we=0.
- frame_done is asserted in the same cycle as the fb_we of the frame's last pixel.
- Coordinate arithmetic never exceeds H_ACTIVE-1 or V_ACTIVE-1; there is no 2^XW wrap.
- Sticky errors clear only on rst.
- Reset mid-frame: everything returns to its reset values, and any pending write is dropped (fb_we=0 in the cycle after rst).
- With s_valid=1 and fb_busy=1, no beat transfers and the state does not change.

Optional Feature:
- Macro: PIXEL_RX_CHECKSUM_EN.
- Defined:
  - frame_sum is the XOR of all s_data written in the current frame, including the restart beat after an err_sof.
  - The accumulator resets on each SOF.
  - frame_sum updates in the same cycle frame_done pulses and holds until the next frame_done.
- Not defined: frame_sum is tied to 0 and no accumulator logic is synthesised.

Test Plan:
All scenarios use H_ACTIVE=4, V_ACTIVE=3.
1. Clean frame: SOF on beat 0, EOL on beats 3/7/11, data=1..12, fb_busy=0 -> 12 writes, (0,0)..(3,2) in raster order, each one cycle after its beat; frame_done pulses with the write of (3,2); frame_count=1; no errors.
2. Backpressure: fb_busy=1 for 5 cycles mid-line with s_valid held at 1 -> s_ready=0, no writes, x/y frozen; the stream resumes with no lost or duplicated pixel.
3. Early and missing EOL: EOL on the 2nd beat of line 0 -> err_eol=1, next beat written at (0,1). No EOL on the 4th beat of line 1 -> line still ends and the next beat is written at (0,2).
4. Mid-frame SOF at (2,1) -> err_sof=1, that beat written at (0,0); a following full frame completes with frame_count=1.
5. Pre-SOF garbage: 3 beats without SOF after reset -> no fb_we; the first SOF beat is written at (0,0).
6. Reset at (1,1) -> all outputs at reset values, fb_we=0 next cycle. Checksum build with data 1..12 -> frame_sum=0x00000C (XOR of 1..12 = 12).
